// File: rtl/store_pack_buf_pkg.sv
// rtl/store_pack_buf_pkg.sv - store size encodings and byte-lane enable constants
package store_pack_buf_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/store_pack_buf_if.sv
// rtl/store_pack_buf_if.sv - store request channel and data-memory issue channel
interface store_pack_buf_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  modport master (
    output req_valid, req_size, req_addr, req_wdata, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req_valid, req_size, req_addr, req_wdata, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_pack_buf_lane_steer.sv
// rtl/store_pack_buf_lane_steer.sv - narrows store data onto byte lanes and flags misalignment
module store_lane_steer
  import store_pack_buf_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        fault
);

  always_comb begin
    wdata = data;
    be    = '0;
    fault = 1'b0;
    case (size_e'(size))
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = BE_BYTE0 << addr_lo;
      end
      SZ_HALF: begin
        wdata = {2{data[15:0]}};
        be    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        fault = addr_lo[0];
      end
      SZ_WORD: begin
        be    = BE_WORD;
        fault = (addr_lo != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_pack_buf.sv
// rtl/store_pack_buf.sv - MEM-stage store FIFO issuing lane-steered writes to data memory
module store_pack_buf #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  store_pack_buf_if.slave            bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       misalign_err,
  output logic [AW-1:0]              err_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] addr_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        st_fault;
  logic        accept, enq, deq;

  store_lane_steer u_steer (
    .size    (bus.req_size),
    .addr_lo (bus.req_addr[1:0]),
    .data    (bus.req_wdata),
    .wdata   (st_wdata),
    .be      (st_be),
    .fault   (st_fault)
  );

  // req_ready comes only from the registered count, never from mem_ready.
  assign bus.req_ready = (count != FULL_CNT);
  assign bus.mem_valid = (count != '0);
  assign bus.mem_addr  = addr_q[rd_ptr];
  assign bus.mem_wdata = wdata_q[rd_ptr];
  assign bus.mem_be    = be_q[rd_ptr];

  assign accept = bus.req_valid && bus.req_ready;
  assign enq    = accept && !st_fault;
  assign deq    = bus.mem_valid && bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      if (enq) begin
        addr_q[wr_ptr]  <= {bus.req_addr[AW-1:2], 2'b00};
        wdata_q[wr_ptr] <= st_wdata;
        be_q[wr_ptr]    <= st_be;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      misalign_err <= accept && st_fault;
      if (accept && st_fault) begin
        err_addr <= bus.req_addr;
      end
    end
  end

endmodule

// File: tb/tb_store_pack_buf.sv
// tb/tb_store_pack_buf.sv - directed and random store traffic checked against a queue model
module tb_store_pack_buf;

  localparam int DEPTH = 2;
  localparam int AW    = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  count;
  logic        misalign_err;
  logic [31:0] err_addr;

  store_pack_buf_if #(.AW(AW)) bus ();

  store_pack_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .count        (count),
    .misalign_err (misalign_err),
    .err_addr     (err_addr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  ent_t        q[$];
  logic        exp_pulse = 1'b0;
  logic [31:0] exp_err_addr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what a store should look like in memory, from size/address rules alone.
  function automatic void model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                output ent_t e, output logic f);
    int lane;
    lane    = int'(a % 4);
    e.addr  = a - (a % 4);
    e.wdata = d;
    e.be    = 4'b0000;
    f       = 1'b0;
    case (sz)
      2'd0: begin
        e.wdata = (d % 256) * 32'h0101_0101;
        e.be    = 4'(1 << lane);
      end
      2'd1: begin
        e.wdata = (d % 65536) * 32'h0001_0001;
        e.be    = (lane >= 2) ? 4'd12 : 4'd3;
        f       = (lane % 2) != 0;
      end
      2'd2: begin
        e.be = 4'd15;
        f    = (lane != 0);
      end
      default: f = 1'b1;
    endcase
  endfunction

  task automatic step();
    ent_t e;
    logic f, acc, deq;
    check("req_ready", bus.req_ready, q.size() < DEPTH);
    acc = bus.req_valid && (q.size() < DEPTH);
    deq = (q.size() != 0) && bus.mem_ready;
    model(bus.req_size, bus.req_addr, bus.req_wdata, e, f);
    if (deq) void'(q.pop_front());
    if (acc && !f) q.push_back(e);
    exp_pulse = acc && f;
    if (exp_pulse) exp_err_addr = bus.req_addr;
    @(posedge clk);
    #1;
    check("count", count, q.size());
    check("mem_valid", bus.mem_valid, q.size() != 0);
    check("misalign_err", misalign_err, exp_pulse);
    check("err_addr", err_addr, exp_err_addr);
    if (q.size() != 0) begin
      check("mem_addr", bus.mem_addr, q[0].addr);
      check("mem_wdata", bus.mem_wdata, q[0].wdata);
      check("mem_be", bus.mem_be, q[0].be);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  initial begin
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_mem_valid", bus.mem_valid, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_be", bus.mem_be, 4'h0);
    check("rst_misalign", misalign_err, 1'b0);
    check("rst_err_addr", err_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Byte store to lane 3
    bus.mem_ready = 1'b1;
    drive(1'b1, 2'd0, 32'h1003, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("byte_valid", bus.mem_valid, 1'b1);
    check("byte_addr", bus.mem_addr, 32'h1000);
    check("byte_wdata", bus.mem_wdata, 32'hEFEF_EFEF);
    check("byte_be", bus.mem_be, 4'b1000);
    step();

    // Half store to upper half, held while memory stalls
    bus.mem_ready = 1'b0;
    drive(1'b1, 2'd1, 32'h2002, 32'h1234_5678);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("half_wdata", bus.mem_wdata, 32'h5678_5678);
    check("half_be", bus.mem_be, 4'b1100);
    check("half_addr", bus.mem_addr, 32'h2000);
    step();
    bus.mem_ready = 1'b1;
    step();

    // Misaligned word
    drive(1'b1, 2'd2, 32'h3001, 32'hCAFE_F00D);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("mis_count", count, 0);
    check("mis_pulse", misalign_err, 1'b1);
    check("mis_err_addr", err_addr, 32'h3001);
    step();
    check("mis_pulse_drop", misalign_err, 1'b0);

    // Backpressure: third word must wait behind a full buffer
    bus.mem_ready = 1'b0;
    drive(1'b1, 2'd2, 32'h0, 32'h1111_1111);
    step();
    drive(1'b1, 2'd2, 32'h4, 32'h2222_2222);
    step();
    drive(1'b1, 2'd2, 32'h8, 32'h3333_3333);
    check("bp_full_ready", bus.req_ready, 1'b0);
    check("bp_full_count", count, 2);
    step();
    check("bp_stall_addr", bus.mem_addr, 32'h0);
    bus.mem_ready = 1'b1;
    step();
    check("bp_order_2", bus.mem_addr, 32'h4);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("bp_order_3", bus.mem_addr, 32'h8);
    step();

    // Simultaneous enqueue/dequeue across pointer wrap
    drive(1'b1, 2'd2, 32'h100, 32'hA000_0000);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 2'd2, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      step();
      check("simul_count", count, 1);
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
      bus.mem_ready = 1'($urandom_range(0, 1));
      step();
    end

    // Async reset with a full buffer
    bus.mem_ready = 1'b0;
    drive(1'b1, 2'd3, 32'h5555, 32'h0);
    step();
    drive(1'b1, 2'd2, 32'h40, 32'h4444_4444);
    step();
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("pre_rst_count", count, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_mem_valid", bus.mem_valid, 1'b0);
    check("arst_count", count, 0);
    check("arst_err_addr", err_addr, 32'h0);
    q.delete();
    exp_err_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    drive(1'b1, 2'd0, 32'h6001, 32'h0000_00A5);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("post_rst_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    check("post_rst_be", bus.mem_be, 4'b0010);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
